nn_perceptron_trainer: RTL and testbench
========================================

Name: nn_perceptron_trainer

Overview:
- Sequential training engine for one neuron of the Q8.8 step-activation network. It is the writer side of the coefficient interface: the inference layers only read coefficients, and this block produces them.
- Accepts one labelled sample per handshake. It recomputes the neuron decision serially with one MAC per cycle, using arithmetic bit-identical to the inference neuron. On a wrong decision it applies the perceptron rule to every coefficient and to the bias.
- Coefficient and bias registers drive the coeff/bias inputs of an inference layer directly.

Parameters:
- WIDTH, 16, data word width; fixed-point Q(WIDTH-FRAC).FRAC.
- FRAC, 8, fractional bits; always WIDTH/2.
- N_IN, 2, number of neuron inputs (coefficients); 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample presented.
- sample_ready  out  1  block can accept a sample.
- sample_x  in  N_IN*WIDTH  inputs; x_i = bits [i*WIDTH +: WIDTH].
- sample_target  in  1  desired neuron output.
- eta  in  WIDTH  learning rate, Q8.8; sampled at accept.
- coeff_out  out  N_IN*WIDTH  current coefficients, same packing as sample_x.
- bias_out  out  WIDTH  current bias.
- pred_out  out  1  neuron decision for the last sample, computed before update.
- err_out  out  1  pred_out != target for the last sample.
- done_valid  out  1  one-cycle pulse; pred_out/err_out/coeff_out final.

Behaviour:
- Reset: coeff_out = 0, bias_out = 0, pred_out = 0, err_out = 0, done_valid = 0, state IDLE. sample_ready = 1 from the first cycle after reset deassertion. rst mid-operation aborts the sample; partial updates are discarded because all registers return to reset values.
- Multiply mul(a,b): unsigned WIDTH x WIDTH product, result = product[FRAC+WIDTH-1 : FRAC]. This exactly matches the inference multiplier. All adds wrap modulo 2^WIDTH unless the optional feature is enabled.
- Activation: pred = (acc != 0) && (acc[WIDTH-1] == 0).
- FSM states:
  - IDLE: sample_ready = 1. On sample_valid && sample_ready, latch x, target and eta; set acc = bias; set idx = 0; go to MAC.
  - MAC: acc += mul(x_idx, coeff_idx), one term per cycle. After N_IN cycles go to DECIDE. sample_ready = 0.
  - DECIDE: 1 cycle. Register pred_out = pred and err_out = (pred != target). If err_out, go to UPDATE with idx = 0; else go to DONE.
  - UPDATE: N_IN+1 cycles. Cycle k < N_IN updates coeff_k ±= mul(eta, x_k); cycle N_IN updates bias ±= eta. Use + when target = 1 (pred was 0) and - when target = 0.
  - DONE: done_valid = 1 for exactly one cycle, then go to IDLE.
- Latency, counted from the accept edge: done_valid is high in cycle N_IN+1 on a correct prediction and in cycle 2*N_IN+2 on an error. For N_IN = 2 that is 3 and 6.
- coeff_out/bias_out change only in UPDATE and are stable at all other times. Downstream inference may sample them on done_valid.
- sample_x, sample_target and eta are ignored outside the accept cycle. Changing them mid-operation has no effect.
- Back-to-back: sample_ready rises in the cycle after done_valid (IDLE). No accept is possible in the DONE cycle.
- A zero input x_k yields a zero delta for coeff_k; the bias is still updated on error.

Optional Feature:
- Macro NN_TRAIN_SAT_EN.
- Defined: UPDATE adds/subtracts use signed saturation; results clamp to 0x7FFF (max positive) or 0x8000 (max negative) on overflow. MAC accumulation still wraps, to stay identical to inference.
- Undefined: UPDATE wraps modulo 2^WIDTH.

Test Plan:
- Reset check: after reset, coeff_out = 0, bias_out = 0, sample_ready = 1, done_valid = 0. Assert rst during MAC -> next cycle everything is at reset values and no done_valid pulse occurs.
- Error update: from reset, eta = 0x0080, x = (0x0100, 0x0100), target 1 -> pred 0, err 1; done_valid in cycle 6; coeff = (0x0080, 0x0080), bias = 0x0080.
- Correct prediction: then same x, target 1 -> acc = 0x0180, pred 1, err 0; done_valid in cycle 3; coeffs unchanged.
- Negative update: then same x, target 0 -> pred 1, err 1; coeffs return to 0, bias = 0.
- Overflow: from reset, eta = 0x4000, x = (0x0100, 0), target 1 twice.
  - First sample -> coeff0 = 0x4000, bias = 0x4000.
  - Second sample: acc wraps to 0x8000, pred 0 -> without macro coeff0 = bias = 0x8000; with NN_TRAIN_SAT_EN coeff0 = bias = 0x7FFF.
- Handshake: hold sample_valid high continuously with 3 distinct samples -> exactly 3 accepts, one per IDLE cycle, with each done_valid preceding the next accept.

Source files
------------

// File: rtl/nn_perceptron_trainer_if.sv
// Sample/coefficient bundle of the perceptron trainer.
// The master presents labelled samples; the slave (the trainer) publishes coefficients and results.
interface nn_perceptron_trainer_if #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 2
);
  logic                   sample_valid;
  logic                   sample_ready;
  logic [N_IN*WIDTH-1:0]  sample_x;
  logic                   sample_target;
  logic [WIDTH-1:0]       eta;
  logic [N_IN*WIDTH-1:0]  coeff_out;
  logic [WIDTH-1:0]       bias_out;
  logic                   pred_out;
  logic                   err_out;
  logic                   done_valid;

  modport master (
    output sample_valid, sample_x, sample_target, eta,
    input  sample_ready, coeff_out, bias_out, pred_out, err_out, done_valid
  );

  modport slave (
    input  sample_valid, sample_x, sample_target, eta,
    output sample_ready, coeff_out, bias_out, pred_out, err_out, done_valid
  );
endinterface

// File: rtl/nn_perceptron_trainer.sv
// Serial perceptron trainer for one Q8.8 step neuron: one MAC per cycle, then a perceptron-rule update on error.
// NN_TRAIN_SAT_EN: coefficient/bias updates saturate instead of wrapping (MAC always wraps).
module nn_perceptron_trainer #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N_IN  = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  nn_perceptron_trainer_if.slave s
);
  localparam int IW = $clog2(N_IN + 1);
  localparam int LW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [IW-1:0] BIAS_IDX = IW'(N_IN);

  typedef enum logic [2:0] {IDLE, MAC, DECIDE, UPDATE, DONE} state_e;

  // Must stay bit-identical to the inference multiplier.
  function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return p[FRAC+WIDTH-1:FRAC];
  endfunction

  function automatic logic [WIDTH-1:0] addsub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                                              input logic up);
    logic [WIDTH-1:0] r;
    r = up ? a + d : a - d;
`ifdef NN_TRAIN_SAT_EN
    if ((up ? (a[WIDTH-1] == d[WIDTH-1]) : (a[WIDTH-1] != d[WIDTH-1])) && (r[WIDTH-1] != a[WIDTH-1]))
      r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return r;
  endfunction

  state_e                         state_q, state_d;
  logic [N_IN-1:0][WIDTH-1:0]     x_q, coeff, lane_upd;
  logic [WIDTH-1:0]               eta_q, acc, bias;
  logic                           tgt_q, pred_q, err_q, pred;
  logic [IW-1:0]                  idx;
  logic [LW-1:0]                  lidx;

  assign lidx = idx[LW-1:0];
  assign pred = (acc != '0) && !acc[WIDTH-1];

  // Per-lane candidate update; only the lane selected by idx is committed.
  genvar g;
  generate
    for (g = 0; g < N_IN; g++) begin : g_lane
      assign lane_upd[g] = addsub(coeff[g], mul(eta_q, x_q[g]), tgt_q);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s.sample_valid) state_d = MAC;
      MAC:     if (idx == LAST_IDX) state_d = DECIDE;
      DECIDE:  state_d = (pred != tgt_q) ? UPDATE : DONE;
      UPDATE:  if (idx == BIAS_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      coeff  <= '0;
      eta_q  <= '0;
      acc    <= '0;
      bias   <= '0;
      tgt_q  <= 1'b0;
      pred_q <= 1'b0;
      err_q  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state_q)
        IDLE: if (s.sample_valid) begin
          x_q   <= s.sample_x;
          tgt_q <= s.sample_target;
          eta_q <= s.eta;
          acc   <= bias;
          idx   <= '0;
        end
        MAC: begin
          acc <= acc + mul(x_q[lidx], coeff[lidx]);
          idx <= idx + 1'b1;
        end
        DECIDE: begin
          pred_q <= pred;
          err_q  <= (pred != tgt_q);
          idx    <= '0;
        end
        UPDATE: begin
          if (idx == BIAS_IDX) bias <= addsub(bias, eta_q, tgt_q);
          else                 coeff[lidx] <= lane_upd[lidx];
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s.sample_ready = (state_q == IDLE);
  assign s.done_valid   = (state_q == DONE);
  assign s.coeff_out    = coeff;
  assign s.bias_out     = bias;
  assign s.pred_out     = pred_q;
  assign s.err_out      = err_q;
endmodule

// File: tb/tb_nn_perceptron_trainer.sv
// Directed bench for nn_perceptron_trainer: reset, error/correct updates, overflow, mid-op reset, back-to-back.
module tb_nn_perceptron_trainer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  nn_perceptron_trainer_if #(.WIDTH(16), .N_IN(2)) s();

  nn_perceptron_trainer #(.WIDTH(16), .FRAC(8), .N_IN(2)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one sample, scramble inputs after accept, measure latency to done_valid.
  task automatic send(input string tag, input logic [15:0] x0, input logic [15:0] x1, input logic t,
                      input logic [15:0] e, input int lat, input logic p, input logic er);
    int  cyc;
    bit  seen;
    chk({tag, "_ready"}, s.sample_ready, 1'b1);
    s.sample_x = {x1, x0}; s.sample_target = t; s.eta = e; s.sample_valid = 1'b1;
    @(posedge clk); #1;
    s.sample_valid = 1'b0; s.sample_x = '1; s.eta = 16'hFFFF; s.sample_target = ~t;
    cyc = 0; seen = 0;
    while (cyc < 40 && !seen) begin
      if (cyc > 0) chk({tag, "_busy"}, s.sample_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
      if (s.done_valid) seen = 1;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_pred"}, s.pred_out, p);
    chk({tag, "_err"}, s.err_out, er);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, s.done_valid, 1'b0);
  endtask

  initial begin
    int accepts, dones, pulses;
    bit order_ok, will_acc;
    s.sample_valid = 1'b0; s.sample_x = '0; s.sample_target = 1'b0; s.eta = '0;

    do_reset();
    chk("rst_coeff", s.coeff_out, 32'h0);
    chk("rst_bias", s.bias_out, 16'h0);
    chk("rst_ready", s.sample_ready, 1'b1);
    chk("rst_done", s.done_valid, 1'b0);
    chk("rst_pred", s.pred_out, 1'b0);
    chk("rst_err", s.err_out, 1'b0);

    send("err_up", 16'h0100, 16'h0100, 1'b1, 16'h0080, 6, 1'b0, 1'b1);
    chk("err_up_coeff", s.coeff_out, 32'h0080_0080);
    chk("err_up_bias", s.bias_out, 16'h0080);

    send("correct", 16'h0100, 16'h0100, 1'b1, 16'h0080, 3, 1'b1, 1'b0);
    chk("correct_coeff", s.coeff_out, 32'h0080_0080);
    chk("correct_bias", s.bias_out, 16'h0080);

    send("neg", 16'h0100, 16'h0100, 1'b0, 16'h0080, 6, 1'b1, 1'b1);
    chk("neg_coeff", s.coeff_out, 32'h0);
    chk("neg_bias", s.bias_out, 16'h0);

    // Build nonzero state, then abort a sample in MAC with reset.
    send("pre_abort", 16'h0100, 16'h0100, 1'b1, 16'h0080, 6, 1'b0, 1'b1);
    s.sample_x = {16'h0100, 16'h0100}; s.sample_target = 1'b0; s.eta = 16'h0080; s.sample_valid = 1'b1;
    @(posedge clk); #1;
    s.sample_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_coeff", s.coeff_out, 32'h0);
    chk("abort_bias", s.bias_out, 16'h0);
    chk("abort_pred", s.pred_out, 1'b0);
    chk("abort_err", s.err_out, 1'b0);
    chk("abort_ready", s.sample_ready, 1'b1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (s.done_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", pulses, 0);

    // Overflow: second sample's accumulator wraps to 0x8000 (negative).
    send("ovf1", 16'h0100, 16'h0000, 1'b1, 16'h4000, 6, 1'b0, 1'b1);
    chk("ovf1_coeff", s.coeff_out, 32'h0000_4000);
    chk("ovf1_bias", s.bias_out, 16'h4000);
    send("ovf2", 16'h0100, 16'h0000, 1'b1, 16'h4000, 6, 1'b0, 1'b1);
`ifdef NN_TRAIN_SAT_EN
    chk("ovf2_coeff", s.coeff_out, 32'h0000_7FFF);
    chk("ovf2_bias", s.bias_out, 16'h7FFF);
`else
    chk("ovf2_coeff", s.coeff_out, 32'h0000_8000);
    chk("ovf2_bias", s.bias_out, 16'h8000);
`endif

    // Back-to-back with sample_valid held high over three samples.
    do_reset();
    accepts = 0; dones = 0; order_ok = 1;
    s.sample_x = {16'h0100, 16'h0100}; s.sample_target = 1'b1; s.eta = 16'h0080;
    s.sample_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      will_acc = s.sample_valid && s.sample_ready;
      if (s.done_valid) dones++;
      if (will_acc) begin
        if (dones != accepts) order_ok = 0;
        accepts++;
      end
      @(posedge clk); #1;
      if (will_acc) begin
        case (accepts)
          1: begin s.sample_x = {16'h0100, 16'h0100}; s.sample_target = 1'b1; end
          2: begin s.sample_x = {16'h0000, 16'h0200}; s.sample_target = 1'b0; end
          default: s.sample_valid = 1'b0;
        endcase
      end
    end
    chk("b2b_accepts", accepts, 3);
    chk("b2b_dones", dones, 3);
    chk("b2b_order", order_ok, 1'b1);
    chk("b2b_coeff", s.coeff_out, 32'h0080_FF80);
    chk("b2b_bias", s.bias_out, 16'h0000);
    chk("b2b_pred", s.pred_out, 1'b1);
    chk("b2b_err", s.err_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
